// File: rtl/bcedn_input_adapter.sv
// -----------------------------------------------------------------------------
// bcedn_input_adapter
//
// Front end of the BCEDN encoder-decoder. Narrow input words are written on
// clkw into an asynchronous FIFO. On clk the read side drains the FIFO and
// packs PACK = DATA_OUT_WIDTH/DATA_IN_WIDTH words into one wide word, with the
// first word of a group in the MSBs. One frame of FRAME_WORDS packed words is
// emitted per start pulse, followed by a one-cycle done pulse.
//
// Optional feature macro: BCEDN_XNOR_EN
//   defined   : data_out = ~(packed ^ WEIGHT), applied at the output register
//   undefined : data_out = packed, WEIGHT unused
//
// Ports
//   clkw        in   write-side clock
//   clk         in   processing clock, asynchronous to clkw
//   rst         in   synchronous active-low reset, sampled in both domains
//   start       in   (clk)  one-cycle pulse that begins a frame
//   in_en       in   (clkw) write strobe
//   data_in     in   (clkw) input word
//   data_out    out  (clk)  packed word, held between out_en pulses
//   out_en      out  (clk)  one-cycle valid pulse per packed word
//   done        out  (clk)  one-cycle pulse at end of frame
//   fifo_wfull  out  (clkw) FIFO full
// -----------------------------------------------------------------------------
module bcedn_input_adapter #(
  parameter int                        DATA_IN_WIDTH  = 8,
  parameter int                        DATA_OUT_WIDTH = 32,
  parameter int                        FIFO_DEPTH     = 16,
  parameter int                        FRAME_WORDS    = 64,
  parameter logic [DATA_OUT_WIDTH-1:0] WEIGHT         = '1
) (
  input  logic                      clkw,
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_en,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      out_en,
  output logic                      done,
  output logic                      fifo_wfull
);

  localparam int PACK  = DATA_OUT_WIDTH / DATA_IN_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int PCW   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int WCW   = $clog2(FRAME_WORDS + 1);
  localparam int TOTAL = FRAME_WORDS * PACK;
  localparam int CCW   = $clog2(TOTAL + 1);

  localparam logic [PCW-1:0] PACK_LAST = PCW'(PACK - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);
  localparam logic [CCW-1:0] POP_TOTAL = CCW'(TOTAL);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_IN_WIDTH-1:0] mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Write side (clkw)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wbin, wbin_next, wgray, wgray_next;
  logic [PW-1:0] rgray_w1, rgray_w2;
  logic [PW-1:0] rgray;
  logic          wr;

  assign wr         = in_en && !fifo_wfull;
  assign wbin_next  = wbin + PW'(wr);
  assign wgray_next = bin2gray(wbin_next);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clkw) begin
    if (!rst) begin
      wbin       <= '0;
      wgray      <= '0;
      rgray_w1   <= '0;
      rgray_w2   <= '0;
      fifo_wfull <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      wgray      <= wgray_next;
      rgray_w1   <= rgray;
      rgray_w2   <= rgray_w1;
      // Compare the post-write pointer so full rises on the same edge as the
      // write that fills the last slot; the very next write is then blocked.
      fifo_wfull <= (wgray_next == {~rgray_w2[PW-1:PW-2], rgray_w2[PW-3:0]});
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and a reset discards contents by clearing both pointers.
  always_ff @(posedge clkw) begin
    if (wr) mem[wbin[AW-1:0]] <= data_in;
  end

  // ---------------------------------------------------------------------------
  // Read side (clk)
  // ---------------------------------------------------------------------------
  state_t                    state, state_next;
  logic [PW-1:0]             rbin, rbin_next, rgray_next;
  logic [PW-1:0]             wgray_r1, wgray_r2;
  logic                      rempty;
  logic                      pop, launch, group_done, frame_last;
  logic                      data_rdy_dl;
  logic [DATA_IN_WIDTH-1:0]  rdata;
  logic [PCW-1:0]            pack_cnt;
  logic [WCW-1:0]            word_cnt;
  logic [CCW-1:0]            pop_cnt;
  logic [DATA_OUT_WIDTH-1:0] pack_reg, packed_next, out_word;

  assign rbin_next  = rbin + PW'(pop);
  assign rgray_next = bin2gray(rbin_next);

  assign group_done = data_rdy_dl && (pack_cnt == PACK_LAST);
  assign frame_last = (word_cnt == WORD_LAST);

  // New word enters from the LSB side; the oldest word of a group drifts up
  // to the MSBs by the time the group completes.
  assign packed_next = (pack_reg << DATA_IN_WIDTH) | DATA_OUT_WIDTH'(rdata);

`ifdef BCEDN_XNOR_EN
  assign out_word = ~(packed_next ^ WEIGHT);
`else
  logic unused_weight;
  assign unused_weight = ^WEIGHT;
  assign out_word      = packed_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          launch     = 1'b1;
        end
      end
      RUN: begin
        // Pops are capped at one frame's worth so later words stay queued.
        pop = !rempty && (pop_cnt != POP_TOTAL);
        if (group_done && frame_last) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rbin        <= '0;
      rgray       <= '0;
      wgray_r1    <= '0;
      wgray_r2    <= '0;
      rempty      <= 1'b1;
      data_rdy_dl <= 1'b0;
      pack_cnt    <= '0;
      word_cnt    <= '0;
      pop_cnt     <= '0;
      pack_reg    <= '0;
      data_out    <= '0;
      out_en      <= 1'b0;
      done        <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      rgray       <= rgray_next;
      wgray_r1    <= wgray;
      wgray_r2    <= wgray_r1;
      rempty      <= (rgray_next == wgray_r2);
      data_rdy_dl <= pop;
      out_en      <= 1'b0;
      // done trails the FIN cycle, i.e. one cycle after the final out_en.
      done        <= (state == FIN);
      if (launch) begin
        pack_cnt <= '0;
        word_cnt <= '0;
        pop_cnt  <= '0;
      end else begin
        if (pop) pop_cnt <= pop_cnt + CCW'(1);
        if (data_rdy_dl) begin
          pack_reg <= packed_next;
          pack_cnt <= group_done ? '0 : pack_cnt + PCW'(1);
          if (group_done) begin
            data_out <= out_word;
            out_en   <= 1'b1;
            word_cnt <= word_cnt + WCW'(1);
          end
        end
      end
    end
  end

  // Read data register; its valid flag is data_rdy_dl.
  always_ff @(posedge clk) begin
    if (pop) rdata <= mem[rbin[AW-1:0]];
  end

endmodule

// File: tb/tb_bcedn_input_adapter.sv
// -----------------------------------------------------------------------------
// tb_bcedn_input_adapter
//
// Directed bench for bcedn_input_adapter with default geometry (8 -> 32 bit,
// 16-entry FIFO, 64-word frames) and WEIGHT = 32'hFFFF0000. Expected words are
// passed through xf(), which applies the XNOR only when BCEDN_XNOR_EN is set.
// -----------------------------------------------------------------------------
module tb_bcedn_input_adapter;

  localparam logic [31:0] W = 32'hFFFF0000;

  logic        clkw = 1'b0;
  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        start = 1'b0;
  logic        in_en = 1'b0;
  logic [7:0]  data_in = '0;
  logic [31:0] data_out;
  logic        out_en, done, fifo_wfull;

  bcedn_input_adapter #(
    .DATA_IN_WIDTH (8),
    .DATA_OUT_WIDTH(32),
    .FIFO_DEPTH    (16),
    .FRAME_WORDS   (64),
    .WEIGHT        (W)
  ) dut (
    .clkw      (clkw),
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_en     (in_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_en    (out_en),
    .done      (done),
    .fifo_wfull(fifo_wfull)
  );

  always #5 clkw = ~clkw;
  always #7 clk  = ~clk;

  int errors = 0;
  int checks = 0;

  // Output monitor, sampled on the falling edge of clk.
  int          cyc = 0;
  int          out_cnt = 0;
  int          done_cnt = 0;
  int          last_out_cyc = 0;
  int          done_cyc = -1;
  logic [31:0] obs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_en) begin
      obs.push_back(data_out);
      out_cnt      <= out_cnt + 1;
      last_out_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  typedef struct packed {
    logic [31:0] words;  // four input bytes, first-written in the MSBs
    logic [31:0] exp;    // packed result before the optional XNOR
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] xf(input logic [31:0] p);
`ifdef BCEDN_XNOR_EN
    return ~(p ^ W);
`else
    return p;
`endif
  endfunction

  function automatic logic [7:0] d_stream(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  function automatic logic [7:0] e_stream(input int i);
    return 8'((i * 11 + 64) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] w);
    int n = 0;
    @(negedge clkw);
    while (fifo_wfull && n < 2000) begin
      @(negedge clkw);
      n++;
    end
    if (fifo_wfull) check("write_stall", {31'b0, fifo_wfull}, 32'h0);
    in_en   = 1'b1;
    data_in = w;
    @(negedge clkw);
    in_en   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_outs(input int target, input string name);
    int n = 0;
    while (out_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 32'(out_cnt), 32'(target));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before the test sequence ended");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{words: {8'h11, 8'h12, 8'h13, 8'h14}, exp: 32'h11121314};
    vecs[1] = '{words: {8'h01, 8'h02, 8'h03, 8'h04}, exp: 32'h01020304};
    vecs[2] = '{words: {8'hFF, 8'h00, 8'hA5, 8'h5A}, exp: 32'hFF00A55A};
    vecs[3] = '{words: {8'h80, 8'h7F, 8'h01, 8'hFE}, exp: 32'h807F01FE};
    vecs[4] = '{words: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, exp: 32'hDEADBEEF};
    vecs[5] = '{words: {8'h00, 8'h00, 8'h00, 8'h00}, exp: 32'h00000000};

    // ---- reset values ----
    repeat (4) @(negedge clkw);
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 32'h0);
    check("rst_out_en", {31'b0, out_en}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_wfull", {31'b0, fifo_wfull}, 32'h0);
    rst = 1'b1;

    // ---- full condition: 17 back-to-back writes, FSM idle ----
    for (int i = 0; i < 17; i++) begin
      @(negedge clkw);
      if (i == 15) check("not_full_15", {31'b0, fifo_wfull}, 32'h0);
      if (i == 16) check("full_16", {31'b0, fifo_wfull}, 32'h1);
      in_en   = 1'b1;
      data_in = 8'(i);
    end
    @(negedge clkw);
    in_en = 1'b0;
    check("full_hold", {31'b0, fifo_wfull}, 32'h1);

    pulse_start();
    wait_outs(1, "full_out_cnt1");
    check("full_out0", obs[0], xf(32'h00010203));
    repeat (3) @(negedge clkw);
    check("full_release", {31'b0, fifo_wfull}, 32'h0);
    wait_outs(4, "full_out_cnt4");
    check("full_out1", obs[1], xf(32'h04050607));
    check("full_out2", obs[2], xf(32'h08090A0B));
    check("full_out3", obs[3], xf(32'h0C0D0E0F));

    // ---- table-driven packing vectors (frame still running) ----
    // Vector 0 also proves word 16 was dropped: a stored 0x10 would lead it.
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < 4; b++) write_word(vecs[v].words[31 - 8 * b -: 8]);
      wait_outs(5 + v, $sformatf("vec%0d_cnt", v));
      check($sformatf("vec%0d_data", v), obs[4 + v], xf(vecs[v].exp));
    end

    // ---- start while busy, then finish the frame with 4 spare words ----
    pulse_start();
    for (int i = 0; i < 220; i++) write_word(d_stream(i));
    wait_outs(64, "frame_cnt");
    repeat (40) @(negedge clk);
    check("frame_exact", 32'(out_cnt), 32'd64);
    check("done_once", 32'(done_cnt), 32'd1);
    check("done_timing", 32'(done_cyc), 32'(last_out_cyc + 1));
    for (int g = 0; g < 54; g++) begin
      check($sformatf("frame_word%0d", 10 + g), obs[10 + g],
            xf({d_stream(4 * g), d_stream(4 * g + 1), d_stream(4 * g + 2), d_stream(4 * g + 3)}));
    end

    // ---- next frame starts from the queued spare words ----
    pulse_start();
    wait_outs(65, "leftover_cnt");
    check("leftover_data", obs[64],
          xf({d_stream(216), d_stream(217), d_stream(218), d_stream(219)}));

    // ---- reset mid-frame: 10 outputs, then a partial group in flight ----
    for (int i = 0; i < 38; i++) write_word(e_stream(i));
    wait_outs(74, "mid_cnt");
    check("mid_word9", obs[73],
          xf({e_stream(32), e_stream(33), e_stream(34), e_stream(35)}));
    repeat (6) @(negedge clk);
    @(negedge clkw);
    rst = 1'b0;
    repeat (6) @(negedge clkw);
    repeat (3) @(negedge clk);
    check("abort_data_out", data_out, 32'h0);
    check("abort_out_en", {31'b0, out_en}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_wfull", {31'b0, fifo_wfull}, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clkw);
    check("abort_no_done", 32'(done_cnt), 32'd1);

    write_word(8'hAA);
    write_word(8'hBB);
    write_word(8'hCC);
    write_word(8'hDD);
    pulse_start();
    wait_outs(75, "post_rst_cnt");
    check("post_rst_data", obs[74], xf(32'hAABBCCDD));
    repeat (20) @(negedge clk);
    check("post_rst_single", 32'(out_cnt), 32'd75);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
